dp_memory: RTL and testbench
============================

# dp_memory

Parametrised dual-port synchronous memory: the next generation of the single-cycle core's combined instruction/data store. Port A is a read-only instruction-fetch port. Port B is a read/write data port. The block adds configurable width and depth, per-port enables with a one-cycle valid strobe, deterministic write-first and cross-port forwarding, and a hardware clear sequencer that zero-fills the array after reset. It sits between the fetch stage (port A) and the load/store unit (port B).

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width; array depth = 2**ADDR_W words
- CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip straight to ready
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- a_en  input  1  port A read request
- a_addr  input  ADDR_W  port A read address
- a_data  output  DATA_W  port A read data, registered
- a_valid  output  1  one-cycle strobe: a_data is new this cycle
- b_en  input  1  port B access request
- b_we  input  1  port B write qualifier, meaningful only with b_en=1
- b_addr  input  ADDR_W  port B address
- b_wdata  input  DATA_W  port B write data
- b_rdata  output  DATA_W  port B read data, registered
- b_valid  output  1  one-cycle strobe: b_rdata is new this cycle
- busy  output  1  clear sequence in progress; all requests ignored

## Operation
- FSM states:
  - CLEAR: active when CLEAR_ON_RESET=1. Writes 0 to mem[clr_cnt], then increments clr_cnt; after writing the last address (2**ADDR_W-1), moves to READY.
  - READY: normal service; stays in READY until reset.
- Reset (rst=0, asynchronous): a_data=0, b_data=0, a_valid=0, b_valid=0, clr_cnt=0. State goes to CLEAR if CLEAR_ON_RESET=1, else READY. busy=1 in CLEAR, 0 in READY.
- Reset asserted mid-CLEAR: sequence restarts from address 0. No partial state is kept.
- While busy=1: a_en and b_en are ignored, both valids stay 0, and data outputs hold 0.
- Port A read (READY, a_en=1): a_data <= mem[a_addr]; a_valid=1 on the next cycle.
- Port B read (READY, b_en=1, b_we=0): b_rdata <= mem[b_addr]; b_valid=1 on the next cycle.
- Port B write (READY, b_en=1, b_we=1): mem[b_addr] <= b_wdata. The port is write-first: b_rdata <= b_wdata and b_valid=1 on the next cycle.
- Collision: a write on B and a read on A in the same cycle with a_addr == b_addr gives a_data <= b_wdata (forwarded, never stale). If the addresses differ, there is no interaction.
- Port idle (en=0): that port's data output holds its last value; its valid is 0.
- The array itself is not reset. Only the CLEAR sequence (or a preload in simulation) defines its contents.
- Addresses wrap naturally modulo 2**ADDR_W. There is no out-of-range condition.

## Timing
- Read latency is 1 cycle on both ports: request at edge N, data and valid present after edge N+1.
- Write takes effect at the edge where it is accepted. A read of the same address on either port at the next edge returns the new data.
- Back-to-back requests every cycle are supported on both ports; throughput is one access per port per cycle.
- CLEAR lasts exactly 2**ADDR_W cycles after reset release. busy falls in the cycle after the final zero write, and the first request is accepted at that edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `dp_memory_pkg`:
  - FSM state encoding: ST_CLEAR, ST_READY.
  - Default width constants: DATA_W_DEF=8, ADDR_W_DEF=8.
- Sub-module `mem_clear_seq` is the natural split. It holds the FSM and clr_cnt and outputs busy, clr_we and clr_addr. The top-level module muxes clr_we/clr_addr against port B's write path.
- Array is a single `reg [DATA_W-1:0] mem [0:2**ADDR_W-1]`, inferable as true dual-port RAM with write-first forwarding logic outside the array.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=4:
  - busy=1 for exactly 16 cycles after release, then 0.
  - A subsequent read of every address on A returns 0x00 with a_valid pulsing 1 cycle after each a_en.
- Write then read: B writes 0x5A to 0x10; next cycle B reads 0x10 → b_rdata=0x5A, b_valid=1. A reads 0x10 → a_data=0x5A.
- Collision: same cycle, B writes 0xC3 to 0x22 and A reads 0x22 → next cycle a_data=0xC3 and b_rdata=0xC3 (write-first).
- Requests during CLEAR: a_en=1, b_en=1, b_we=1 (0xFF to 0x03) at cycle 5 of CLEAR → no valids. After busy falls, a read of 0x03 returns 0x00.
- Reset mid-CLEAR: rst pulsed low at cycle 9 → outputs return to 0 immediately, and busy stays high for a full 16 cycles after the new release.
- Idle hold and wrap:
  - B reads 0xFF (data 0x77), then b_en=0 for 3 cycles → b_rdata stays 0x77 and b_valid=0.
  - With ADDR_W=8, write 0x11 to 0xFF and read 0xFF → 0x11.

Source files
------------

// File: rtl/dp_memory_pkg.sv
// Shared types and default sizes for the dual-port instruction/data store.
package dp_memory_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in READY.
module mem_clear_seq
   import dp_memory_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o,
   output state_e            state_o
);

   state_e            state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic              busy_q;

   // A reset at any point restarts the walk from address 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (CLEAR_ON_RESET) begin
            state_q <= ST_CLEAR;
         end else begin
            state_q <= ST_READY;
         end
         busy_q    <= CLEAR_ON_RESET;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (&clr_cnt_q) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign clr_we_o   = (state_q == ST_CLEAR);
   assign clr_addr_o = clr_cnt_q;
   assign state_o    = state_q;

endmodule

// File: rtl/dp_memory.sv
// Dual-port synchronous store: port A read-only fetch, port B read/write data,
// write-first on B and B-to-A forwarding on same-address collisions.
module dp_memory
   import dp_memory_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   input  logic              b_en,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_valid,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   reg [DATA_W-1:0] mem [0:DEPTH-1];

   logic              seq_busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   state_e            seq_state;

   mem_clear_seq #(
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .busy_o     (seq_busy),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .state_o    (seq_state)
   );

   logic ready;
   logic a_rd;
   logic b_acc;
   logic b_wr;
   logic fwd;

   assign ready = (seq_state == ST_READY);
   assign a_rd  = ready & a_en;
   assign b_acc = ready & b_en;
   assign b_wr  = b_acc & b_we;
   assign fwd   = a_rd & b_wr & (a_addr == b_addr);

   // The sequencer owns the write port while clearing; port B is gated off then.
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign wr_en   = clr_we | b_wr;
   assign wr_addr = clr_we ? clr_addr : b_addr;
   assign wr_data = clr_we ? '0 : b_wdata;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   logic [DATA_W-1:0] a_data_q, a_data_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              a_valid_q;
   logic              b_valid_q;

   // Array reads see the pre-write contents, so new write data is muxed in here.
   always_comb begin
      a_data_d  = a_data_q;
      b_rdata_d = b_rdata_q;
      if (!ready) begin
         a_data_d  = '0;
         b_rdata_d = '0;
      end else begin
         if (a_rd) begin
            a_data_d = fwd ? b_wdata : mem[a_addr];
         end
         if (b_acc) begin
            b_rdata_d = b_we ? b_wdata : mem[b_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_data_q  <= '0;
         b_rdata_q <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         a_data_q  <= a_data_d;
         b_rdata_q <= b_rdata_d;
         a_valid_q <= a_rd;
         b_valid_q <= b_acc;
      end
   end

   assign a_data  = a_data_q;
   assign a_valid = a_valid_q;
   assign b_rdata = b_rdata_q;
   assign b_valid = b_valid_q;
   assign busy    = seq_busy;

endmodule

// File: tb/tb_dp_memory.sv
// Bench for dp_memory: a 16-word instance for the clear/reset sequences and a
// 256-word instance for table vectors and randomized traffic against a model.
module tb_dp_memory;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic          a4_en, b4_en, b4_we, a4_valid, b4_valid, busy4;
   logic [3:0]    a4_addr, b4_addr;
   logic [DW-1:0] b4_wdata, a4_data, b4_rdata;

   logic          a8_en, b8_en, b8_we, a8_valid, b8_valid, busy8;
   logic [7:0]    a8_addr, b8_addr;
   logic [DW-1:0] b8_wdata, a8_data, b8_rdata;

   dp_memory #(.DATA_W(DW), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) u4 (
      .clk(clk), .rst(rst),
      .a_en(a4_en), .a_addr(a4_addr), .a_data(a4_data), .a_valid(a4_valid),
      .b_en(b4_en), .b_we(b4_we), .b_addr(b4_addr), .b_wdata(b4_wdata),
      .b_rdata(b4_rdata), .b_valid(b4_valid), .busy(busy4)
   );

   dp_memory #(.DATA_W(DW), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)) u8 (
      .clk(clk), .rst(rst),
      .a_en(a8_en), .a_addr(a8_addr), .a_data(a8_data), .a_valid(a8_valid),
      .b_en(b8_en), .b_we(b8_we), .b_addr(b8_addr), .b_wdata(b8_wdata),
      .b_rdata(b8_rdata), .b_valid(b8_valid), .busy(busy8)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the array as plain storage plus the last value seen on each port.
   logic [DW-1:0] mdl_mem [0:255];
   logic [DW-1:0] exp_a_data, exp_b_data;
   logic          exp_a_valid, exp_b_valid;

   typedef struct {
      logic       ae;
      logic [7:0] aa;
      logic       be;
      logic       bw;
      logic [7:0] ba;
      logic [7:0] bd;
      logic       eav;
      logic [7:0] ead;
      logic       ebv;
      logic [7:0] ebd;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic op4(input logic ae, input logic [3:0] aa, input logic be, input logic bw,
                      input logic [3:0] ba, input logic [7:0] bd);
      a4_en = ae; a4_addr = aa; b4_en = be; b4_we = bw; b4_addr = ba; b4_wdata = bd;
      @(posedge clk); #1;
   endtask

   task automatic op8(input logic ae, input logic [7:0] aa, input logic be, input logic bw,
                      input logic [7:0] ba, input logic [7:0] bd);
      a8_en = ae; a8_addr = aa; b8_en = be; b8_we = bw; b8_addr = ba; b8_wdata = bd;
      if (ae) exp_a_data = (be && bw && (ba == aa)) ? bd : mdl_mem[aa];
      exp_a_valid = ae;
      if (be) begin
         exp_b_data = bw ? bd : mdl_mem[ba];
         if (bw) mdl_mem[ba] = bd;
      end
      exp_b_valid = be;
      @(posedge clk); #1;
   endtask

   task automatic idle4();
      a4_en = 1'b0; a4_addr = '0; b4_en = 1'b0; b4_we = 1'b0; b4_addr = '0; b4_wdata = '0;
   endtask

   // Asynchronous assertion away from any edge; outputs must drop at once.
   task automatic pulse_reset(input string tag);
      idle4();
      rst = 1'b0;
      #1;
      check({tag, "_a_data"}, a4_data, 0);
      check({tag, "_b_rdata"}, b4_rdata, 0);
      check({tag, "_valids"}, {a4_valid, b4_valid}, 0);
      check({tag, "_busy"}, {busy4, busy8}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Counts edges after release until each instance drops busy; optionally
   // fires a full request on the small instance after edge 'inject'.
   task automatic count_clear(input int inject, output int c4, output int c8);
      c4 = -1;
      c8 = -1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clk); #1;
         if (busy4) check("busy_quiet", {a4_valid, b4_valid, a4_data, b4_rdata}, 0);
         if (!busy4 && c4 < 0) c4 = cyc;
         if (!busy8) begin
            c8 = cyc;
            break;
         end
         if (cyc == inject) begin
            a4_en = 1'b1; a4_addr = 4'h3; b4_en = 1'b1; b4_we = 1'b1; b4_addr = 4'h3; b4_wdata = 8'hFF;
         end else begin
            idle4();
         end
      end
      idle4();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c4, c8;
      rst = 1'b0;
      idle4();
      a8_en = 1'b0; a8_addr = '0; b8_en = 1'b0; b8_we = 1'b0; b8_addr = '0; b8_wdata = '0;
      for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
      exp_a_data = '0; exp_b_data = '0; exp_a_valid = 1'b0; exp_b_valid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_a_data", a4_data, 0);
      check("rst_b_rdata", b4_rdata, 0);
      check("rst_valids", {a4_valid, b4_valid, a8_valid, b8_valid}, 0);
      check("rst_busy", {busy4, busy8}, 2'b11);
      @(negedge clk);
      rst = 1'b1;

      count_clear(5, c4, c8);
      check("clear_len4", c4, 16);
      check("clear_len8", c8, 256);

      op4(1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 8'h00);
      check("ignored_wr_valid", a4_valid, 1);
      check("ignored_wr_data", a4_data, 8'h00);

      for (int i = 0; i < 16; i++) begin
         op4(1'b0, 4'h0, 1'b1, 1'b1, 4'(i), 8'(8'hA0 + i));
         check("fill_b_valid", b4_valid, 1);
         check("fill_b_rdata", b4_rdata, 8'hA0 + i);
      end
      op4(1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 8'h00);
      check("fill_readback", a4_data, 8'hA7);

      pulse_reset("rst_async");
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #1;
         check("midclear_busy", busy4, 1);
      end
      pulse_reset("rst_midclear");
      count_clear(0, c4, c8);
      check("reclear_len4", c4, 16);
      check("reclear_len8", c8, 256);

      for (int i = 0; i < 16; i++) begin
         op4(1'b1, 4'(i), 1'b0, 1'b0, 4'h0, 8'h00);
         check("zero_a_valid", a4_valid, 1);
         check("zero_a_data", a4_data, 8'h00);
      end
      op4(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00);
      check("a_valid_pulse", a4_valid, 0);

      //          ae    aa     be    bw    ba     bd     eav   ead    ebv   ebd
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h5A};
      tbl[1]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A};
      tbl[2]  = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 8'hC3, 1'b1, 8'hC3, 1'b1, 8'hC3};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'hC3, 1'b1, 8'hC3};
      tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h77, 1'b1, 8'h00, 1'b1, 8'h77};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h77};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h99, 1'b0, 8'h00, 1'b0, 8'h77};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h77};
      tbl[9]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'h11, 1'b1, 8'h11, 1'b1, 8'h11};
      tbl[10] = '{1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h11, 1'b1, 8'h11};
      tbl[11] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h00};
      tbl[12] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h10, 8'hE1, 1'b1, 8'hC3, 1'b1, 8'hE1};
      tbl[13] = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hE1, 1'b0, 8'hE1};

      for (int i = 0; i < 14; i++) begin
         op8(tbl[i].ae, tbl[i].aa, tbl[i].be, tbl[i].bw, tbl[i].ba, tbl[i].bd);
         check("tbl_a_valid", a8_valid, tbl[i].eav);
         check("tbl_a_data", a8_data, tbl[i].ead);
         check("tbl_b_valid", b8_valid, tbl[i].ebv);
         check("tbl_b_rdata", b8_rdata, tbl[i].ebd);
      end

      for (int i = 0; i < 600; i++) begin
         logic       ae, be, bw;
         logic [7:0] aa, ba, bd;
         ae = 1'($urandom_range(0, 1));
         be = 1'($urandom_range(0, 1));
         bw = 1'($urandom_range(0, 1));
         aa = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         ba = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         bd = 8'($urandom_range(0, 255));
         op8(ae, aa, be, bw, ba, bd);
         check("rnd_a_valid", a8_valid, exp_a_valid);
         check("rnd_a_data", a8_data, exp_a_data);
         check("rnd_b_valid", b8_valid, exp_b_valid);
         check("rnd_b_rdata", b8_rdata, exp_b_data);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
